// File: rtl/vx_cache_dispatch_pkg.sv
// vx_cache_dispatch_pkg: width helpers, the FSM state type and bank selection for the core-request dispatcher.
package vx_cache_dispatch_pkg;

   typedef enum logic {IDLE, DISPATCH} state_e;

   function automatic int line_sel_bits(input int line_size, input int word_size);
      return $clog2(line_size / word_size);
   endfunction

   function automatic int bank_sel_bits(input int num_banks);
      return $clog2(num_banks);
   endfunction

   function automatic int req_idx_bits(input int num_requests);
      return num_requests > 1 ? $clog2(num_requests) : 1;
   endfunction

   // With a single bank the mask collapses to zero, so every lane lands on bank 0.
   function automatic int bank_select(input logic [63:0] addr, input int lsb, input int num_banks);
      return int'((addr >> lsb) & 64'(num_banks - 1));
   endfunction

endpackage

// File: rtl/vx_rr_pick.sv
// vx_rr_pick: picks one requester from a mask, round-robin from ptr or fixed lowest-index priority.
module vx_rr_pick #(
   parameter int N  = 4,
   parameter int W  = 2,
   parameter bit RR = 1'b1
) (
   input  logic [N-1:0] mask,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] grant,
   output logic         valid
);

   logic [W-1:0] base;

   assign base  = RR ? ptr : '0;
   assign valid = |mask;

   // Scanning from the far end lets the smallest offset from base win.
   always_comb begin
      grant = '0;
      for (int k = N - 1; k >= 0; k--)
         if (mask[(int'(base) + k) % N]) grant = W'((int'(base) + k) % N);
   end

endmodule

// File: rtl/vx_cache_core_req_bank_dispatch.sv
// vx_cache_core_req_bank_dispatch: captures a multi-lane core request batch and steers each lane
// to its bank, serialising same-bank conflicts with per-bank arbitration.
module vx_cache_core_req_bank_dispatch
   import vx_cache_dispatch_pkg::*;
#(
   parameter int  BANK_LINE_SIZE  = 16,
   parameter int  WORD_SIZE       = 4,
   parameter int  NUM_BANKS       = 4,
   parameter int  NUM_REQUESTS    = 4,
   parameter int  WORD_ADDR_WIDTH = 30,
   parameter int  TAG_WIDTH       = 8,
   parameter bit  ARB_RR          = 1'b1,
   localparam int LINE_SEL_BITS   = line_sel_bits(BANK_LINE_SIZE, WORD_SIZE),
   localparam int BANK_SEL_BITS   = bank_sel_bits(NUM_BANKS),
   localparam int REQ_IDX_BITS    = req_idx_bits(NUM_REQUESTS)
) (
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic [NUM_REQUESTS-1:0]                       core_req_valid,
   input  logic [NUM_REQUESTS-1:0][WORD_ADDR_WIDTH-1:0]  core_req_addr,
   input  logic [TAG_WIDTH-1:0]                          core_req_tag,
   output logic                                          core_req_ready,
   output logic [NUM_BANKS-1:0]                          per_bank_valid,
   output logic [NUM_BANKS-1:0][REQ_IDX_BITS-1:0]        per_bank_req_idx,
   output logic [NUM_BANKS-1:0][WORD_ADDR_WIDTH-1:0]     per_bank_addr,
   output logic [NUM_BANKS-1:0][TAG_WIDTH-1:0]           per_bank_tag,
   input  logic [NUM_BANKS-1:0]                          per_bank_ready,
   output logic                                          busy,
   output logic [31:0]                                   conflict_cycles
);

   localparam int BW = BANK_SEL_BITS > 0 ? BANK_SEL_BITS : 1;

   state_e                                        state, state_next;
   logic [NUM_REQUESTS-1:0]                       pending, pending_next, clr;
   logic [NUM_REQUESTS-1:0][WORD_ADDR_WIDTH-1:0]  addr_q;
   logic [NUM_REQUESTS-1:0][BW-1:0]               bank_q;
   logic [TAG_WIDTH-1:0]                          tag_q;
   logic [NUM_BANKS-1:0][REQ_IDX_BITS-1:0]        rr_ptr, grant;
   logic [NUM_BANKS-1:0][NUM_REQUESTS-1:0]        bank_mask;
   logic [NUM_BANKS-1:0]                          fire, more;
   logic                                          accept;

   // more[b]: bank b fires while another of its lanes still waits behind the grant.
   always_comb begin
      bank_mask = '0;
      clr       = '0;
      fire      = '0;
      more      = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         for (int i = 0; i < NUM_REQUESTS; i++)
            bank_mask[b][i] = pending[i] & (int'(bank_q[i]) == b);
         fire[b] = per_bank_valid[b] & per_bank_ready[b];
         if (fire[b]) clr[grant[b]] = 1'b1;
         more[b] = fire[b] & |(bank_mask[b] & ~(NUM_REQUESTS'(1) << grant[b]));
      end
   end

   assign pending_next   = pending & ~clr;
   assign core_req_ready = (state == IDLE) | ((state == DISPATCH) & (pending_next == '0));
   assign accept         = |core_req_valid & core_req_ready;
   assign busy           = (state == DISPATCH);

   always_comb begin
      state_next = state;
      if (accept) state_next = DISPATCH;
      else if (pending_next == '0) state_next = IDLE;
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      vx_rr_pick #(
         .N  (NUM_REQUESTS),
         .W  (REQ_IDX_BITS),
         .RR (ARB_RR)
      ) u_pick (
         .mask  (bank_mask[b]),
         .ptr   (rr_ptr[b]),
         .grant (grant[b]),
         .valid (per_bank_valid[b])
      );
      assign per_bank_req_idx[b] = grant[b];
      assign per_bank_addr[b]    = addr_q[grant[b]];
      assign per_bank_tag[b]     = tag_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else state <= state_next;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending         <= '0;
         addr_q          <= '0;
         bank_q          <= '0;
         tag_q           <= '0;
         rr_ptr          <= '0;
         conflict_cycles <= '0;
      end else begin
         pending <= accept ? core_req_valid : pending_next;
         if (accept) begin
            tag_q <= core_req_tag;
            for (int i = 0; i < NUM_REQUESTS; i++) begin
               addr_q[i] <= core_req_addr[i];
               bank_q[i] <= BW'(bank_select(64'(core_req_addr[i]), LINE_SEL_BITS, NUM_BANKS));
            end
         end
         for (int b = 0; b < NUM_BANKS; b++)
            if (fire[b]) rr_ptr[b] <= REQ_IDX_BITS'((int'(grant[b]) + 1) % NUM_REQUESTS);
         if (|more && conflict_cycles != '1) conflict_cycles <= conflict_cycles + 32'd1;
      end
   end

endmodule
